// File: rtl/io_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : io_ctrl_pkg                                                 |
// | Brief  : Register map, STATUS/CTRL bit positions for io_port_ctrl.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package io_ctrl_pkg;

  localparam logic [2:0] c_sel_addr_l  = 3'd0;
  localparam logic [2:0] c_sel_addr_h  = 3'd1;
  localparam logic [2:0] c_sel_data    = 3'd2;
  localparam logic [2:0] c_sel_ctrl    = 3'd3;
  localparam logic [2:0] c_sel_status  = 3'd4;
  localparam logic [2:0] c_sel_in_data = 3'd5;

  localparam int c_st_empty     = 0;
  localparam int c_st_full      = 1;
  localparam int c_st_overflow  = 2;
  localparam int c_st_in_full   = 3;
  localparam int c_st_count_lsb = 4;

  localparam int c_ctrl_auto_inc = 0;
  localparam int c_ctrl_flush    = 1;

  localparam int c_fifo_width = 24;

  function automatic logic [7:0] pack_status(input logic       empty,
                                             input logic       full,
                                             input logic       overflow,
                                             input logic       in_full,
                                             input logic [3:0] count);
    logic [7:0] s;
    s                             = '0;
    s[c_st_empty]                 = empty;
    s[c_st_full]                  = full;
    s[c_st_overflow]              = overflow;
    s[c_st_in_full]               = in_full;
    s[c_st_count_lsb +: 4]        = count;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : io_fifo                                                     |
// | Brief  : Zero-latency FIFO with flush; head reads as zero when empty.|
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module io_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign count  = r_count;
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign dout   = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/io_port_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : io_port_controller                                          |
// | Brief  : Register-mapped output FIFO and single-byte input holder.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module io_port_controller
  import io_ctrl_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter bit AUTO_INC_RST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_we,
  input  logic        reg_re,
  input  logic [2:0]  reg_sel,
  input  logic [7:0]  bus,
  output logic [7:0]  rd_data,
  output logic [15:0] out_address_bus,
  output logic [7:0]  out_data_bus,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0]             r_addr;
  logic                    r_auto_inc;
  logic                    r_overflow;
  logic                    r_in_full;
  logic [7:0]              r_in_byte;

  logic [c_fifo_width-1:0] w_fifo_dout;
  logic                    w_full;
  logic                    w_empty;
  logic [CW-1:0]           w_count;
  logic                    w_wr_data;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_flush;
  logic                    w_ovf_set;
  logic                    w_st_rd;
  logic                    w_in_rd;
  logic                    w_in_cap;

  assign w_wr_data = reg_we && (reg_sel == c_sel_data);
  assign w_pop     = !w_empty && out_ready;
  assign w_flush   = reg_we && (reg_sel == c_sel_ctrl) && bus[c_ctrl_flush];
  assign w_push    = w_wr_data && (!w_full || w_pop) && !w_flush;
  assign w_ovf_set = w_wr_data && w_full && !w_pop;
  assign w_st_rd   = reg_re && (reg_sel == c_sel_status);
  assign w_in_rd   = reg_re && (reg_sel == c_sel_in_data);
  assign w_in_cap  = in_valid && !r_in_full;

  io_fifo #(
    .WIDTH (c_fifo_width),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   ({r_addr, bus}),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign out_valid       = !w_empty;
  assign out_address_bus = w_fifo_dout[23:8];
  assign out_data_bus    = w_fifo_dout[7:0];
  assign in_ready        = !r_in_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr     <= '0;
      r_auto_inc <= AUTO_INC_RST;
    end else begin
      if (reg_we && (reg_sel == c_sel_addr_l)) r_addr[7:0]  <= bus;
      if (reg_we && (reg_sel == c_sel_addr_h)) r_addr[15:8] <= bus;
      if (reg_we && (reg_sel == c_sel_ctrl))   r_auto_inc   <= bus[c_ctrl_auto_inc];
      if (w_push && r_auto_inc)                r_addr       <= r_addr + 16'd1;
    end
  end

  // A new overflow in the same cycle as a STATUS read must survive the read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (w_flush) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (w_st_rd) begin
      r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_full <= 1'b0;
      r_in_byte <= '0;
    end else if (w_in_cap) begin
      r_in_full <= 1'b1;
      r_in_byte <= in_data;
    end else if (w_in_rd) begin
      r_in_full <= 1'b0;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (reg_sel)
      c_sel_status:  rd_data = pack_status(w_empty, w_full, r_overflow, r_in_full, 4'(w_count));
      c_sel_in_data: rd_data = r_in_byte;
      default:       rd_data = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_io_port_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_io_port_controller                                       |
// | Brief  : Scoreboard bench with a queue-based model of the port.      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_io_port_controller;
  import io_ctrl_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reg_we = 1'b0;
  logic        reg_re = 1'b0;
  logic [2:0]  reg_sel = 3'd6;
  logic [7:0]  bus = 8'h00;
  logic [7:0]  rd_data;
  logic [15:0] out_address_bus;
  logic [7:0]  out_data_bus;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;

  io_port_controller #(.DEPTH(DEPTH), .AUTO_INC_RST(1'b0)) dut (
    .clk             (clk),
    .rst             (rst),
    .reg_we          (reg_we),
    .reg_re          (reg_re),
    .reg_sel         (reg_sel),
    .bus             (bus),
    .rd_data         (rd_data),
    .out_address_bus (out_address_bus),
    .out_data_bus    (out_data_bus),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: occupancy, address register, flags and the expected output stream.
  logic [23:0] sb_q[$];
  int          m_cnt  = 0;
  logic [15:0] m_addr = '0;
  bit          m_inc  = 1'b0;
  bit          m_ovf  = 1'b0;
  bit          m_inf  = 1'b0;
  logic [7:0]  m_held = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_status();
    logic [7:0] s;
    s = {4'(m_cnt), m_inf, m_ovf, (m_cnt == DEPTH), (m_cnt == 0)};
    return s;
  endfunction

  task automatic model_reset();
    sb_q.delete();
    m_cnt = 0; m_addr = '0; m_inc = 1'b0; m_ovf = 1'b0; m_inf = 1'b0; m_held = '0;
  endtask

  // Inputs are already driven; check combinational reads, clock once, update model.
  task automatic step();
    logic [7:0] exp_rd;
    bit pop, full, wr_data, push_ok, flush, ovf_set, st_rd;
    #1;
    case (reg_sel)
      c_sel_status:  exp_rd = exp_status();
      c_sel_in_data: exp_rd = m_held;
      default:       exp_rd = 8'h00;
    endcase
    check("rd_data", rd_data, exp_rd);
    check("in_ready", in_ready, !m_inf);
    pop     = (m_cnt > 0) && out_ready;
    full    = (m_cnt == DEPTH);
    wr_data = reg_we && (reg_sel == c_sel_data);
    flush   = reg_we && (reg_sel == c_sel_ctrl) && bus[1];
    push_ok = wr_data && (!full || pop) && !flush;
    ovf_set = wr_data && full && !pop;
    st_rd   = reg_re && (reg_sel == c_sel_status);
    @(posedge clk);
    if (reg_we && reg_sel == c_sel_addr_l) m_addr[7:0]  = bus;
    if (reg_we && reg_sel == c_sel_addr_h) m_addr[15:8] = bus;
    if (reg_we && reg_sel == c_sel_ctrl)   m_inc        = bus[0];
    if (flush) begin
      sb_q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      if (push_ok) begin
        sb_q.push_back({m_addr, bus});
        if (m_inc) m_addr = m_addr + 16'd1;
      end
      m_cnt = m_cnt + int'(push_ok) - int'(pop);
      if (ovf_set)    m_ovf = 1'b1;
      else if (st_rd) m_ovf = 1'b0;
    end
    if (in_valid && !m_inf) begin
      m_inf  = 1'b1;
      m_held = in_data;
    end else if (reg_re && reg_sel == c_sel_in_data) begin
      m_inf = 1'b0;
    end
    #1;
  endtask

  task automatic drive(input bit we, input bit re, input logic [2:0] sel, input logic [7:0] d);
    reg_we = we; reg_re = re; reg_sel = sel; bus = d;
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 3'd6, 8'h00);
  endtask

  // Monitor: compare the presented head against the scoreboard, pop on handshake.
  always @(negedge clk) begin
    if (rst) begin
      check("out_valid", out_valid, sb_q.size() != 0);
      if (sb_q.size() != 0) begin
        check("head", {out_address_bus, out_data_bus}, sb_q[0]);
        if (out_ready) void'(sb_q.pop_front());
      end else begin
        check("idle_bus", {out_address_bus, out_data_bus}, 24'h0);
      end
    end
  end

  initial begin
    reg_sel = c_sel_status;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_status", rd_data, 8'h01);
    rst = 1'b1;

    // Basic push with explicit address.
    out_ready = 1'b0;
    drive(1, 0, c_sel_addr_l, 8'h34);
    drive(1, 0, c_sel_addr_h, 8'h12);
    drive(1, 0, c_sel_data,   8'hAB);
    reg_we = 1'b0; reg_sel = c_sel_status; #1;
    check("basic_valid", out_valid, 1'b1);
    check("basic_addr", out_address_bus, 16'h1234);
    check("basic_data", out_data_bus, 8'hAB);
    check("basic_status", rd_data, 8'h10);
    out_ready = 1'b1; idle(2);

    // Auto-increment across a byte boundary.
    out_ready = 1'b0;
    drive(1, 0, c_sel_ctrl,   8'h01);
    drive(1, 0, c_sel_addr_l, 8'hFF);
    drive(1, 0, c_sel_addr_h, 8'h00);
    for (int i = 0; i < 3; i++) drive(1, 0, c_sel_data, 8'h10 + 8'(i));
    drive(1, 0, c_sel_data, 8'h77);
    reg_we = 1'b0; #1;
    check("inc_head0", out_address_bus, 16'h00FF);
    out_ready = 1'b1; idle(5);

    // Overflow on a full FIFO, then cleared by a STATUS read.
    out_ready = 1'b0;
    drive(1, 0, c_sel_ctrl, 8'h00);
    for (int i = 0; i < 5; i++) drive(1, 0, c_sel_data, 8'hC0 + 8'(i));
    reg_we = 1'b0; reg_sel = c_sel_status; #1;
    check("ovf_status", rd_data, 8'h46);
    drive(0, 1, c_sel_status, 8'h00);
    reg_re = 1'b0; #1;
    check("ovf_cleared", rd_data, 8'h42);

    // Full FIFO with same-cycle pop accepts the push without overflow.
    out_ready = 1'b1;
    drive(1, 0, c_sel_data, 8'hEE);
    out_ready = 1'b0; reg_we = 1'b0; reg_sel = c_sel_status; #1;
    check("fullpop_status", rd_data, 8'h42);
    out_ready = 1'b1; idle(5);

    // Input holding register.
    in_valid = 1'b1; in_data = 8'h5A;
    idle(1);
    in_valid = 1'b0; in_data = 8'h00;
    reg_sel = c_sel_status; #1;
    check("in_hold_ready", in_ready, 1'b0);
    check("in_hold_status", rd_data[3], 1'b1);
    reg_sel = c_sel_in_data; #1;
    check("in_read", rd_data, 8'h5A);
    drive(0, 1, c_sel_in_data, 8'h00);
    reg_re = 1'b0;
    check("in_released", in_ready, 1'b1);

    // Asynchronous reset with entries queued.
    out_ready = 1'b0;
    drive(1, 0, c_sel_addr_l, 8'h40);
    for (int i = 0; i < 3; i++) drive(1, 0, c_sel_data, 8'h90 + 8'(i));
    reg_we = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_bus", {out_address_bus, out_data_bus}, 24'h0);
    model_reset();
    @(posedge clk); #1 rst = 1'b1;
    reg_sel = c_sel_status; #1;
    check("arst_status", rd_data, 8'h01);
    drive(1, 0, c_sel_data, 8'h3C);
    reg_we = 1'b0; #1;
    check("arst_addr", out_address_bus, 16'h0000);
    out_ready = 1'b1; idle(2);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      reg_sel   = 3'($urandom_range(0, 7));
      bus       = 8'($urandom);
      if (reg_sel == c_sel_ctrl) bus[1] = ($urandom_range(0, 7) == 0);
      reg_we    = ($urandom_range(0, 3) != 0);
      reg_re    = ($urandom_range(0, 2) == 0);
      step();
    end

    reg_we = 1'b0; reg_re = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    idle(DEPTH + 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/io_port_controller.md
IO_PORT_CONTROLLER -- requirements
Module: io_port_controller

Interface
REQ-001 SHALL have parameter DEPTH, default 4: output FIFO entries; power of two, 2..8.
REQ-002 SHALL have parameter AUTO_INC_RST, default 0: reset value of CTRL.auto_inc.
REQ-003 SHALL have port: clk  in  1  clock; all logic is rising-edge.
REQ-004 SHALL have port: rst  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have ports: reg_we  in  1  register write strobe; reg_re  in  1  register read strobe.
REQ-006 SHALL have port: reg_sel  in  3  register select.
REQ-007 SHALL have ports: bus  in  8  write data; rd_data  out  8  read data.
REQ-008 SHALL have ports: out_address_bus  out  16  head address; out_data_bus  out  8  head data; out_valid  out  1  FIFO non-empty; out_ready  in  1  sink accepts.
REQ-009 SHALL have ports: in_data  in  8  device byte; in_valid  in  1  device byte offered; in_ready  out  1  holding register empty.

Function
REQ-010 SHALL decode reg_sel: 0 ADDR_L (W), 1 ADDR_H (W), 2 DATA (W, push), 3 CTRL (W), 4 STATUS (R), 5 IN_DATA (R); codes 6-7 write no-op, read 0x00.
REQ-011 SHALL, on reg_we to ADDR_L/ADDR_H, load bus into addr_reg[7:0]/[15:8] at the next edge.
REQ-012 SHALL, on reg_we to DATA, push {addr_reg, bus} into the FIFO at the next edge, if not full or a pop occurs in the same cycle.
REQ-013 SHALL drop a DATA write when full with no same-cycle pop, and set sticky STATUS.overflow.
REQ-014 SHALL, when CTRL.auto_inc=1 and a push is accepted, increment addr_reg by 1, wrapping 0xFFFF to 0x0000; dropped pushes do not increment.
REQ-015 SHALL, on reg_we to CTRL, load auto_inc from bus[0]; bus[1]=1 is a self-clearing flush that empties the FIFO and clears overflow.
REQ-016 SHALL give flush priority over any same-cycle push or pop.
REQ-017 SHALL drive out_valid = FIFO non-empty, with out_address_bus/out_data_bus = head entry; outputs 0 when empty.
REQ-018 SHALL pop one entry on an edge where out_valid && out_ready; simultaneous push and pop leave count unchanged.
REQ-019 SHALL drive rd_data combinationally from reg_sel, regardless of reg_re.
REQ-020 SHALL format STATUS as: bit0 empty, bit1 full, bit2 overflow, bit3 in_full, bits7:4 count.
REQ-021 SHALL clear overflow on an edge with reg_re && reg_sel==STATUS, unless a new overflow occurs in that cycle (set wins).
REQ-022 SHALL drive in_ready = !in_full, and capture in_data with in_full set on an edge where in_valid && in_ready.
REQ-023 SHALL return the held byte on an IN_DATA read, or its stale value if in_full=0; an edge with reg_re && reg_sel==IN_DATA clears in_full.
REQ-024 SHALL process reg_we and reg_re in the same cycle independently.
REQ-025 SHALL add no latency: push visible on out_valid the cycle after the write edge.

Reset
REQ-026 SHALL, while rst=0, immediately clear addr_reg, FIFO pointers/count, overflow, in_full, and the held byte; auto_inc takes AUTO_INC_RST.
REQ-027 SHALL have out_valid=0, in_ready=1, out buses 0x0000/0x00 during reset; a reset mid-transfer discards all FIFO contents.

Structure
REQ-028 SHALL place reg_sel codes, STATUS bit positions, and CTRL bit positions in shared package io_ctrl_pkg.
REQ-029 SHALL implement the FIFO as sub-module io_fifo (params WIDTH=24, DEPTH; push/pop/flush, full/empty/count).

Verification
REQ-030 SHALL cover: ADDR_L=0x34, ADDR_H=0x12, DATA=0xAB, out_ready=0 -> next cycle out_valid=1, addr 0x1234, data 0xAB, STATUS=0x10.
REQ-031 SHALL cover: CTRL=0x01, ADDR=0x00FF, three DATA writes -> heads at 0x00FF, 0x0100, 0x0101; addr_reg=0x0102.
REQ-032 SHALL cover: DEPTH=4, out_ready=0, five DATA writes -> count 4, full=1, overflow=1 (STATUS=0x46); STATUS read -> 0x42.
REQ-033 SHALL cover: full FIFO, out_ready=1 with a same-cycle DATA write -> push accepted, count stays 4, no overflow.
REQ-034 SHALL cover: in_valid=1, in_data=0x5A -> in_ready=0, STATUS bit3=1; IN_DATA read -> 0x5A, in_ready=1 next cycle.
REQ-035 SHALL cover: rst=0 asserted with 3 entries queued -> out_valid=0 immediately; after release count=0, addr_reg=0.
